// File: rtl/instr_loader_3.sv
// Boot-time program loader: parses a 16-bit word-count header plus little-endian
// instruction words from a byte stream and writes them to instruction memory.
module instr_loader_3 #(
   parameter int ADDR_W    = 6,
   parameter int MAX_WORDS = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [63:0]       imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [15:0]       r_len;
   logic [1:0]        r_byte_cnt;
   logic [31:0]       r_word;
   logic [ADDR_W:0]   r_word_count;
   logic [63:0]       r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              w_accept;
   logic [15:0]       w_len_full;
   logic [ADDR_W:0]   w_count_inc;

   assign w_accept    = byte_valid && byte_ready;
   assign w_len_full  = {byte_in, r_len[7:0]};
   assign w_count_inc = r_word_count + {{ADDR_W{1'b0}}, 1'b1};

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (load_start) w_state_next = S_LEN_LO;
            else            w_state_next = S_IDLE;
         end
         S_LEN_LO: begin
            if (w_accept) w_state_next = S_LEN_HI;
            else          w_state_next = S_LEN_LO;
         end
         S_LEN_HI: begin
            if (!w_accept)                           w_state_next = S_LEN_HI;
            else if (w_len_full == 16'd0)            w_state_next = S_DONE;
            else if (w_len_full > 16'(MAX_WORDS))    w_state_next = S_ERR;
            else                                     w_state_next = S_DATA;
         end
         S_DATA: begin
            if (w_accept && (r_byte_cnt == 2'd3)) w_state_next = S_WRITE;
            else                                  w_state_next = S_DATA;
         end
         S_WRITE: begin
            if (16'(w_count_inc) == r_len) w_state_next = S_DONE;
            else                           w_state_next = S_DATA;
         end
         S_DONE, S_ERR: begin
            if (load_start) w_state_next = S_LEN_LO;
            else            w_state_next = r_state;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Header, word assembly and write-port datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len        <= 16'd0;
         r_byte_cnt   <= 2'd0;
         r_word       <= 32'd0;
         r_word_count <= {(ADDR_W+1){1'b0}};
         r_imem_addr  <= 64'd0;
         r_imem_wdata <= 32'd0;
      end else begin
         case (r_state)
            S_LEN_LO: begin
               if (w_accept) r_len[7:0] <= byte_in;
            end
            S_LEN_HI: begin
               if (w_accept) begin
                  r_len[15:8]  <= byte_in;
                  r_word_count <= {(ADDR_W+1){1'b0}};
                  r_byte_cnt   <= 2'd0;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  case (r_byte_cnt)
                     2'd0:    r_word[7:0]   <= byte_in;
                     2'd1:    r_word[15:8]  <= byte_in;
                     2'd2:    r_word[23:16] <= byte_in;
                     default: r_word[31:24] <= byte_in;
                  endcase
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  // Latch the write port on the 4th byte so it is valid throughout WRITE
                  if (r_byte_cnt == 2'd3) begin
                     r_imem_addr  <= 64'({r_word_count, 2'b00});
                     r_imem_wdata <= {byte_in, r_word[23:0]};
                  end
               end
            end
            S_WRITE: begin
               r_word_count <= w_count_inc;
               r_byte_cnt   <= 2'd0;
            end
            default: begin
            end
         endcase
      end
   end

   // Moore output decode
   always_comb begin
      byte_ready = 1'b0;
      imem_we    = 1'b0;
      core_reset = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (r_state)
         S_LEN_LO, S_LEN_HI, S_DATA: byte_ready = 1'b1;
         S_WRITE:                    imem_we    = 1'b1;
         S_DONE: begin
            core_reset = 1'b0;
            done       = 1'b1;
         end
         S_ERR:                      error      = 1'b1;
         default: begin
         end
      endcase
   end

   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign word_count = r_word_count;

endmodule
